gpr_dbg_access_ctrl: RTL and testbench
======================================

Name: gpr_dbg_access_ctrl

Overview:
- Sequences debug-module abstract register accesses (read/write of x0..x31) into the GPR file.
- Arbitrates the single GPR write port between core writeback and debug writes. Core writeback always has priority.
- Drives a dedicated GPR read address for debug reads.
- Returns data, an ack pulse and a cmderr-style status to the debug module.

Parameters:
- GPR_BASE_ADDR, 16'h1000, abstract regno base for GPRs; only addresses GPR_BASE_ADDR..GPR_BASE_ADDR+31 are valid.
- TIMEOUT_CYCLES, 64, write-port wait limit. Used only when GPRCTRL_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- dm_req_i  in  1  single-cycle command strobe
- dm_we_i  in  1  1 = write GPR, 0 = read GPR
- dm_addr_i  in  16  abstract regno
- dm_wdata_i  in  32  write data
- dm_ack_o  out  1  one-cycle completion pulse
- dm_rdata_o  out  32  read data, valid with dm_ack_o and held until next ack
- dm_err_o  out  3  status, valid with dm_ack_o: 0 ok, 2 not supported, 3 timeout, 4 not halted
- busy_o  out  1  high from the cycle after accept through the ack cycle
- halted_i  in  1  core halted
- core_wb_en_i  in  1  core writeback enable
- core_wb_addr_i  in  5  core writeback address
- core_wb_data_i  in  32  core writeback data
- gpr_we_o  out  1  GPR write enable (muxed)
- gpr_waddr_o  out  5  GPR write address (muxed)
- gpr_wdata_o  out  32  GPR write data (muxed)
- gpr_raddr_o  out  5  debug read address into GPR file
- gpr_rdata_i  in  32  combinational read data for gpr_raddr_o

Behaviour:
Reset:
- FSM enters IDLE.
- All outputs are 0, including dm_rdata_o, busy_o and gpr_raddr_o.
- Latched command registers are cleared.

State IDLE:
- dm_req_i=1 latches we, addr[15:0] and wdata, then moves to DECODE.
- dm_req_i while busy_o=1 is ignored; no queueing.

State DECODE (1 cycle), checks in priority order:
- addr outside the GPR range -> err=2, go to RESP.
- halted_i=0 -> err=4, go to RESP.
- Read -> READ.
- Write -> WPORT.

State READ (1 cycle):
- gpr_raddr_o = addr[4:0].
- gpr_rdata_i is captured into dm_rdata_o at the clock edge; go to RESP.
- Reading x0 returns 0.

State WPORT:
- If core_wb_en_i=1: the core owns the port and the block stays in WPORT.
- If core_wb_en_i=0: drive gpr_we_o=1, gpr_waddr_o=addr[4:0], gpr_wdata_o=wdata for exactly this cycle, then go to RESP with err=0.
- A write to x0 asserts gpr_we_o; the GPR file discards it. Status is ok.

State RESP (1 cycle):
- dm_ack_o=1 with dm_err_o; go to IDLE.

Write-port mux:
- Outside the WPORT write cycle, gpr_we/waddr/wdata pass core_wb_* through combinationally.
- The core and debug never write in the same cycle.

Latency (accept edge = cycle 0):
- Read: ack in cycle 3.
- Uncontended write: ack in cycle 3; each contended cycle adds 1.
- Error: ack in cycle 2.

Boundary conditions:
- halted_i is sampled only in DECODE. Deassertion afterwards does not abort the command.
- rst_i mid-command: immediate return to IDLE; no write issued; no ack.
- dm_rdata_o is not updated by writes or errors; it keeps the last read value.

Optional Feature:
- Macro: GPRCTRL_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WPORT and increments each stalled cycle.
  - When it reaches TIMEOUT_CYCLES, go to RESP with err=3; no write is issued.
  - A free port in the same cycle as expiry wins, and the write completes with err=0.
- Undefined:
  - No counter logic is synthesized.
  - WPORT waits indefinitely; err=3 is never produced.

Test Plan:
1. halted_i=1, pre-load x5=32'h6, read addr 16'h1005 -> ack in cycle 3, dm_rdata_o=32'h6, err=0, gpr_raddr_o=5 during READ.
2. halted_i=1, write addr 16'h100D data 32'hDEADBEEF, core idle -> single gpr_we_o pulse with waddr=13 in cycle 2, ack in cycle 3 with err=0; readback returns 32'hDEADBEEF.
3. Write 16'h1004 while core_wb_en_i=1 for 5 cycles (waddr=9) -> core writes pass through untouched; debug write lands the cycle after core_wb_en_i drops; ack delayed 5 cycles.
4. halted_i=0, read 16'h1002 -> ack in cycle 2, err=4, no GPR write. Addr 16'h1020 -> err=2. Extra dm_req_i pulses while busy_o=1 are ignored.
5. With GPRCTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8, hold core_wb_en_i=1 -> err=3 after 8 stall cycles, no debug write.
6. Assert rst_i in WPORT -> no ack, no gpr_we_o from debug, all outputs 0. A new read after reset completes normally.

Source files
------------

// File: rtl/gpr_dbg_access_ctrl.sv
// ============================================================================
// gpr_dbg_access_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Turns debug-module abstract register commands (read or write of x0..x31)
//   into accesses on the GPR file. It also shares the single GPR write port
//   between core writeback and debug writes. Core writeback always wins the
//   port. Each command returns a one-cycle ack with a cmderr-style status.
//
//   Command flow:  IDLE -> DECODE -> READ  -> RESP -> IDLE
//                                 -> WPORT -> RESP
//                                 -> RESP (error)
//
// Optional feature (macro GPRCTRL_TIMEOUT_EN):
//   When the macro is defined, a debug write that waits TIMEOUT_CYCLES stalled
//   cycles for the write port gives up and reports status 3 (timeout). When it
//   is not defined, no counter is built and WPORT waits as long as needed.
//
// Parameters:
//   GPR_BASE_ADDR   abstract regno of x0. Valid range is base .. base+31.
//   TIMEOUT_CYCLES  write-port wait limit. Used only with GPRCTRL_TIMEOUT_EN.
//
// Ports:
//   clk_i, rst_i     clock and asynchronous active-high reset
//   dm_req_i         single-cycle command strobe. Ignored while busy_o=1.
//   dm_we_i          1 = write GPR, 0 = read GPR
//   dm_addr_i[15:0]  abstract regno
//   dm_wdata_i[31:0] write data
//   dm_ack_o         one-cycle completion pulse
//   dm_rdata_o[31:0] last read data. Written only by successful reads.
//   dm_err_o[2:0]    status, valid with dm_ack_o:
//                    0 ok, 2 not supported, 3 timeout, 4 not halted
//   busy_o           high from the cycle after accept through the ack cycle
//   halted_i         core halted. Sampled only in DECODE.
//   core_wb_*        core writeback request (enable, address, data)
//   gpr_we_o, gpr_waddr_o, gpr_wdata_o   muxed GPR write port
//   gpr_raddr_o[4:0] debug read address into the GPR file
//   gpr_rdata_i      combinational read data for gpr_raddr_o
// ============================================================================
module gpr_dbg_access_ctrl #(
  parameter logic [15:0] GPR_BASE_ADDR  = 16'h1000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // Debug module command / response
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [15:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [31:0] dm_rdata_o,
  output logic [2:0]  dm_err_o,
  output logic        busy_o,
  // Core status and writeback
  input  logic        halted_i,
  input  logic        core_wb_en_i,
  input  logic [4:0]  core_wb_addr_i,
  input  logic [31:0] core_wb_data_i,
  // GPR file
  output logic        gpr_we_o,
  output logic [4:0]  gpr_waddr_o,
  output logic [31:0] gpr_wdata_o,
  output logic [4:0]  gpr_raddr_o,
  input  logic [31:0] gpr_rdata_i
);

  // --------------------------------------------------------------------------
  // FSM encoding and status codes
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_WPORT  = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_NOTSUP  = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_HALT    = 3'd4;

  // --------------------------------------------------------------------------
  // State and latched command
  // --------------------------------------------------------------------------
  logic [2:0]  r_state;
  logic        r_we;
  logic [15:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_err;
  logic [31:0] r_rdata;

  // --------------------------------------------------------------------------
  // Address decode on the latched regno.
  // The register index is the offset from the base. With a 32-aligned base
  // this is the same as addr[4:0]. It also stays correct if the base is moved
  // to an unaligned value.
  // --------------------------------------------------------------------------
  logic [15:0] w_offset;
  logic        w_in_range;
  logic [4:0]  w_idx;

  assign w_offset   = r_addr - GPR_BASE_ADDR;
  assign w_in_range = (r_addr >= GPR_BASE_ADDR) && (w_offset[15:5] == 11'd0);
  assign w_idx      = w_offset[4:0];

  // The debug write fires only in a WPORT cycle where the core leaves the
  // port free, so the core and debug never collide.
  logic w_dbg_wr;
  assign w_dbg_wr = (r_state == ST_WPORT) && !core_wb_en_i;

  // --------------------------------------------------------------------------
  // Optional write-port wait timeout
  // --------------------------------------------------------------------------
  logic w_expire;

`ifdef GPRCTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;

  // Expiry is the stalled cycle that brings the count to TIMEOUT_CYCLES.
  // A free port in that cycle takes the write path instead, because the
  // FSM checks w_dbg_wr before it checks w_expire.
  assign w_expire = (r_state == ST_WPORT) && core_wb_en_i &&
                    (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_DECODE) begin
      // DECODE is the only way into WPORT, so clearing here means the count
      // starts at zero on WPORT entry.
      r_wait_cnt <= '0;
    end else if ((r_state == ST_WPORT) && core_wb_en_i) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Command sequencer
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= 16'd0;
      r_wdata <= 32'd0;
      r_err   <= ERR_OK;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A request is accepted only here. Requests that arrive in any
          // other state are dropped, so there is no queueing.
          if (dm_req_i) begin
            r_we    <= dm_we_i;
            r_addr  <= dm_addr_i;
            r_wdata <= dm_wdata_i;
            r_err   <= ERR_OK;
            r_state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          // The range check has priority over the halt check. halted_i is
          // looked at only here, so a later deassert does not abort.
          if (!w_in_range) begin
            r_err   <= ERR_NOTSUP;
            r_state <= ST_RESP;
          end else if (!halted_i) begin
            r_err   <= ERR_HALT;
            r_state <= ST_RESP;
          end else if (r_we) begin
            r_state <= ST_WPORT;
          end else begin
            r_state <= ST_READ;
          end
        end

        ST_READ: begin
          // x0 reads as zero whatever the GPR file returns for index 0.
          r_rdata <= (w_idx == 5'd0) ? 32'd0 : gpr_rdata_i;
          r_state <= ST_RESP;
        end

        ST_WPORT: begin
          if (w_dbg_wr) begin
            r_err   <= ERR_OK;
            r_state <= ST_RESP;
          end else if (w_expire) begin
            r_err   <= ERR_TIMEOUT;
            r_state <= ST_RESP;
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Write-port mux and debug read address
  // --------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first. A path that does
  // not assign a variable would otherwise infer a latch.
  always_comb begin
    gpr_we_o    = 1'b0;
    gpr_waddr_o = 5'd0;
    gpr_wdata_o = 32'd0;
    gpr_raddr_o = 5'd0;
    // The whole port is forced low during reset. This keeps every output at
    // zero while rst_i is high, even if the core drives a writeback then.
    if (!rst_i) begin
      if (w_dbg_wr) begin
        gpr_we_o    = 1'b1;
        gpr_waddr_o = w_idx;
        gpr_wdata_o = r_wdata;
      end else begin
        gpr_we_o    = core_wb_en_i;
        gpr_waddr_o = core_wb_addr_i;
        gpr_wdata_o = core_wb_data_i;
      end
      if (r_state == ST_READ) begin
        gpr_raddr_o = w_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Debug module response
  // --------------------------------------------------------------------------
  assign dm_ack_o   = (r_state == ST_RESP);
  assign dm_err_o   = (r_state == ST_RESP) ? r_err : ERR_OK;
  assign dm_rdata_o = r_rdata;
  assign busy_o     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gpr_dbg_access_ctrl.sv
// ============================================================================
// tb_gpr_dbg_access_ctrl
// ----------------------------------------------------------------------------
// Directed bench for gpr_dbg_access_ctrl. The bench holds a behavioural GPR
// file, and that file is updated from the muxed write port. Each command
// pushes its expected response (data, status, latency) into a scoreboard
// queue. The entry is popped and compared when the ack arrives.
// If GPRCTRL_TIMEOUT_EN is defined, the DUT is built with TIMEOUT_CYCLES=8
// and a timeout case is added.
// ============================================================================
module tb_gpr_dbg_access_ctrl;

  localparam logic [31:0] CORE_D = 32'h9999_0000;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  err;
    int          lat;
  } exp_t;

  logic        clk_i;
  logic        rst_i;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [15:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic [2:0]  dm_err_o;
  logic        busy_o;
  logic        halted_i;
  logic        core_wb_en_i;
  logic [4:0]  core_wb_addr_i;
  logic [31:0] core_wb_data_i;
  logic        gpr_we_o;
  logic [4:0]  gpr_waddr_o;
  logic [31:0] gpr_wdata_o;
  logic [4:0]  gpr_raddr_o;
  logic [31:0] gpr_rdata_i;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  // Observations recorded by run_cmd for each command
  int          lat;
  int          dbg_cnt;
  int          dbg_cyc;
  logic [4:0]  dbg_waddr;
  logic [31:0] dbg_wdata;
  logic [4:0]  raddr_c2;
  logic        busy_c1;
  int          core_pass;

`ifdef GPRCTRL_TIMEOUT_EN
  gpr_dbg_access_ctrl #(.GPR_BASE_ADDR(16'h1000), .TIMEOUT_CYCLES(8)) dut (
`else
  gpr_dbg_access_ctrl #(.GPR_BASE_ADDR(16'h1000)) dut (
`endif
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .dm_req_i      (dm_req_i),
    .dm_we_i       (dm_we_i),
    .dm_addr_i     (dm_addr_i),
    .dm_wdata_i    (dm_wdata_i),
    .dm_ack_o      (dm_ack_o),
    .dm_rdata_o    (dm_rdata_o),
    .dm_err_o      (dm_err_o),
    .busy_o        (busy_o),
    .halted_i      (halted_i),
    .core_wb_en_i  (core_wb_en_i),
    .core_wb_addr_i(core_wb_addr_i),
    .core_wb_data_i(core_wb_data_i),
    .gpr_we_o      (gpr_we_o),
    .gpr_waddr_o   (gpr_waddr_o),
    .gpr_wdata_o   (gpr_wdata_o),
    .gpr_raddr_o   (gpr_raddr_o),
    .gpr_rdata_i   (gpr_rdata_i)
  );

  // Behavioural GPR file. x0 writes are discarded and x0 is never loaded.
  logic [31:0] gpr_mem [32];
  always @(posedge clk_i) begin
    if (gpr_we_o && gpr_waddr_o != 5'd0) gpr_mem[gpr_waddr_o] <= gpr_wdata_o;
  end
  assign gpr_rdata_i = gpr_mem[gpr_raddr_o];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic expect_resp(input logic [31:0] rdata, input logic [2:0] err, input int l);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.lat   = l;
    sb.push_back(e);
  endtask

  // Issues one command. Cycle 0 is the accept cycle. In cycles st_from..st_to
  // the core holds the write port. inject keeps dm_req_i high through cycle 1,
  // when the DUT is busy. drop_halt clears halted_i from cycle 2 onward.
  task automatic run_cmd(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                         input int st_from, input int st_to, input bit inject,
                         input bit drop_halt);
    int   cyc;
    bit   got;
    exp_t e;
    logic [31:0] a_rdata;
    logic [2:0]  a_err;
    cyc = 0; got = 0; lat = -1;
    dbg_cnt = 0; dbg_cyc = -1; dbg_waddr = '0; dbg_wdata = '0;
    raddr_c2 = '1; busy_c1 = 1'b0; core_pass = 0;
    a_rdata = '0; a_err = '0;
    @(posedge clk_i); #1;
    dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata;
    while (!got && cyc < 200) begin
      @(posedge clk_i); #1;
      cyc++;
      dm_req_i     = inject && (cyc == 1);
      core_wb_en_i = (cyc >= st_from) && (cyc <= st_to);
      if (drop_halt && cyc >= 2) halted_i = 1'b0;
      @(negedge clk_i);
      if (cyc == 1) busy_c1 = busy_o;
      if (cyc == 2) raddr_c2 = gpr_raddr_o;
      if (gpr_we_o === 1'b1 && !core_wb_en_i) begin
        dbg_cnt++; dbg_cyc = cyc; dbg_waddr = gpr_waddr_o; dbg_wdata = gpr_wdata_o;
      end
      if (core_wb_en_i && gpr_we_o === 1'b1 && gpr_waddr_o === core_wb_addr_i &&
          gpr_wdata_o === core_wb_data_i) core_pass++;
      if (dm_ack_o === 1'b1) begin
        got = 1; lat = cyc; a_rdata = dm_rdata_o; a_err = dm_err_o;
      end
    end
    dm_req_i = 1'b0;
    core_wb_en_i = 1'b0;
    check("ack_seen", {31'd0, got}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (got) begin
        check("ack_err", {29'd0, a_err}, {29'd0, e.err});
        check("ack_rdata", a_rdata, e.rdata);
        check("ack_latency", lat, e.lat);
      end
    end
  endtask

  initial begin
    int n_ack;
    rst_i = 1'b1; dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    halted_i = 1'b1; core_wb_en_i = 1'b0; core_wb_addr_i = '0; core_wb_data_i = '0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_ack", {31'd0, dm_ack_o}, 32'd0);
    check("rst_err", {29'd0, dm_err_o}, 32'd0);
    check("rst_rdata", dm_rdata_o, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_raddr", {27'd0, gpr_raddr_o}, 32'd0);
    check("rst_we", {31'd0, gpr_we_o}, 32'd0);
    rst_i = 1'b0;

    // Preload x5 = 6 through core writeback (pass-through while idle)
    @(posedge clk_i); #1;
    core_wb_en_i = 1'b1; core_wb_addr_i = 5'd5; core_wb_data_i = 32'h6;
    @(negedge clk_i);
    check("pass_we", {31'd0, gpr_we_o}, 32'd1);
    check("pass_waddr", {27'd0, gpr_waddr_o}, 32'd5);
    check("pass_wdata", gpr_wdata_o, 32'h6);
    @(posedge clk_i); #1;
    core_wb_en_i = 1'b0; core_wb_addr_i = 5'd9; core_wb_data_i = CORE_D;

    // T1: read x5
    expect_resp(32'h6, 3'd0, 3);
    run_cmd(1'b0, 16'h1005, 32'h0, 0, -1, 0, 0);
    check("t1_raddr", {27'd0, raddr_c2}, 32'd5);
    check("t1_busy_c1", {31'd0, busy_c1}, 32'd1);
    check("t1_no_write", dbg_cnt, 0);

    // T2: write x13, then read back; dm_rdata_o holds the prior read value
    expect_resp(32'h6, 3'd0, 3);
    run_cmd(1'b1, 16'h100D, 32'hDEADBEEF, 0, -1, 0, 0);
    check("t2_we_cnt", dbg_cnt, 1);
    check("t2_we_cyc", dbg_cyc, 2);
    check("t2_waddr", {27'd0, dbg_waddr}, 32'd13);
    check("t2_wdata", dbg_wdata, 32'hDEADBEEF);
    expect_resp(32'hDEADBEEF, 3'd0, 3);
    run_cmd(1'b0, 16'h100D, 32'h0, 0, -1, 0, 0);

    // x0: write still pulses the port, read returns zero
    expect_resp(32'hDEADBEEF, 3'd0, 3);
    run_cmd(1'b1, 16'h1000, 32'h1234, 0, -1, 0, 0);
    check("x0_we_cnt", dbg_cnt, 1);
    check("x0_waddr", {27'd0, dbg_waddr}, 32'd0);
    expect_resp(32'h0, 3'd0, 3);
    run_cmd(1'b0, 16'h1000, 32'h0, 0, -1, 0, 0);
    expect_resp(32'hDEADBEEF, 3'd0, 3);
    run_cmd(1'b0, 16'h100D, 32'h0, 0, -1, 0, 0);

    // T3: contended write, core holds the port for cycles 2..6
    expect_resp(32'hDEADBEEF, 3'd0, 8);
    run_cmd(1'b1, 16'h1004, 32'hCAFE0004, 2, 6, 0, 0);
    check("t3_we_cnt", dbg_cnt, 1);
    check("t3_we_cyc", dbg_cyc, 7);
    check("t3_waddr", {27'd0, dbg_waddr}, 32'd4);
    check("t3_core_pass", core_pass, 5);
    expect_resp(32'hCAFE0004, 3'd0, 3);
    run_cmd(1'b0, 16'h1004, 32'h0, 0, -1, 0, 0);
    expect_resp(CORE_D, 3'd0, 3);
    run_cmd(1'b0, 16'h1009, 32'h0, 0, -1, 0, 0);

    // halted_i dropping after DECODE does not abort the write
    expect_resp(CORE_D, 3'd0, 3);
    run_cmd(1'b1, 16'h1011, 32'h11, 0, -1, 0, 1);
    check("halt_drop_we_cnt", dbg_cnt, 1);
    halted_i = 1'b1;
    expect_resp(32'h11, 3'd0, 3);
    run_cmd(1'b0, 16'h1011, 32'h0, 0, -1, 0, 0);

    // T4: error paths, with an extra request while busy
    halted_i = 1'b0;
    expect_resp(32'h11, 3'd4, 2);
    run_cmd(1'b0, 16'h1002, 32'h0, 0, -1, 1, 0);
    check("t4_no_write", dbg_cnt, 0);
    n_ack = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (dm_ack_o === 1'b1 || busy_o === 1'b1) n_ack++;
    end
    check("t4_busy_req_ignored", n_ack, 0);
    expect_resp(32'h11, 3'd4, 2);
    run_cmd(1'b1, 16'h1002, 32'h5555, 0, -1, 0, 0);
    check("t4_wr_no_write", dbg_cnt, 0);
    expect_resp(32'h11, 3'd2, 2);
    run_cmd(1'b0, 16'h1020, 32'h0, 0, -1, 0, 0);
    halted_i = 1'b1;
    expect_resp(32'h11, 3'd2, 2);
    run_cmd(1'b0, 16'h1020, 32'h0, 0, -1, 0, 0);
    expect_resp(32'h11, 3'd2, 2);
    run_cmd(1'b1, 16'h0FFF, 32'h77, 0, -1, 0, 0);
    check("t4_oor_no_write", dbg_cnt, 0);

`ifdef GPRCTRL_TIMEOUT_EN
    // T5: port held through expiry -> timeout after 8 stalled cycles
    expect_resp(32'h11, 3'd3, 10);
    run_cmd(1'b1, 16'h1003, 32'h3333, 2, 12, 0, 0);
    check("t5_no_write", dbg_cnt, 0);
`endif

    // T6: reset while the command waits in WPORT
    @(posedge clk_i); #1;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 16'h100D; dm_wdata_i = 32'h55;
    @(posedge clk_i); #1;
    dm_req_i = 1'b0; core_wb_en_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("t6_busy_pre", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("t6_ack", {31'd0, dm_ack_o}, 32'd0);
    check("t6_busy", {31'd0, busy_o}, 32'd0);
    check("t6_we", {31'd0, gpr_we_o}, 32'd0);
    check("t6_rdata", dm_rdata_o, 32'd0);
    check("t6_err", {29'd0, dm_err_o}, 32'd0);
    check("t6_raddr", {27'd0, gpr_raddr_o}, 32'd0);
    n_ack = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (dm_ack_o !== 1'b0 || gpr_we_o !== 1'b0) n_ack++;
    end
    check("t6_quiet_in_reset", n_ack, 0);
    rst_i = 1'b0; core_wb_en_i = 1'b0;

    // After reset: x13 still holds the earlier value, and x5 is intact
    expect_resp(32'hDEADBEEF, 3'd0, 3);
    run_cmd(1'b0, 16'h100D, 32'h0, 0, -1, 0, 0);
    expect_resp(32'h6, 3'd0, 3);
    run_cmd(1'b0, 16'h1005, 32'h0, 0, -1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
